fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences the instruction memory: owns the PC, drives its byte read address each cycle, and captures the returned big-endian 32-bit word.
- Buffers fetched words with their PCs in a small prefetch queue that decode drains via valid/ready.
- Handles branch/jump redirects (flush + new PC), memory end-of-range stop, and misaligned-target faults.
- Sits between the instruction memory and the decode stage of the MIPS-32 core.

Parameters:
- MEM_BYTES, 20: instruction memory size in bytes. Must be a multiple of 4 and ≥4.
- DEPTH, 2: prefetch queue entries. Power of two, 2..8.
- RESET_PC, 0: PC loaded at reset. Must be word aligned.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_en  in  1  1 = fetching allowed; 0 = hold PC and push nothing.
- imem_addr  out  32  byte read address to instruction memory; always equals the PC register.
- imem_instr  in  32  combinational read data for imem_addr.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head.
- inst_out  out  32  queue head instruction.
- inst_pc  out  32  PC of the queue head.
- redirect_valid  in  1  one-cycle request to load redirect_target.
- redirect_target  in  32  new byte PC.
- fault  out  1  sticky; set on a misaligned redirect.
- fetch_count  out  16  words pushed since reset; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc = RESET_PC; queue empty; state = RUN.
  - inst_valid = 0; inst_out = 0; inst_pc = 0; fault = 0; fetch_count = 0.
  - imem_addr = RESET_PC.
- Reset asserted mid-operation discards all queue contents and any pending redirect.
- States:
  - RUN: fetching.
  - END: PC past the end of memory; no fetch.
  - FAULT: terminal until reset.
- Push condition, all of the following true:
  - state == RUN, fetch_en == 1, redirect_valid == 0;
  - pc + 4 ≤ MEM_BYTES (compare in 33-bit arithmetic, no overflow);
  - queue not full, or a pop occurs in the same cycle.
- On push: enqueue {imem_instr, pc}; pc += 4; fetch_count += 1.
- If RUN and pc + 4 > MEM_BYTES: go to END with no push. The PC is held.
- Pop:
  - Occurs when inst_valid && inst_ready.
  - Head advances; the next entry is visible the following cycle.
  - Push and pop in the same cycle when full are both honoured; occupancy is unchanged.
- Latency:
  - A word fetched at edge N is presented on inst_out after edge N (zero bubbles when empty).
  - From reset release, the first inst_valid is seen after the first clk edge.
- Redirect (highest priority, handled in RUN or END):
  - A pop in the same cycle is honoured (decode consumed that word).
  - All other queue entries are flushed; inst_valid = 0 on the next cycle.
  - No push that cycle.
  - target[1:0] != 0: state = FAULT, fault = 1, pc unchanged.
  - Otherwise: pc = target and state = RUN. If target is out of range, the next cycle moves to END.
- FAULT:
  - No push.
  - Redirects are ignored.
  - The queue still drains to decode.
  - fault stays 1 until reset.
- fetch_en = 0: pc and state hold; the queue still drains; redirects still apply.
- Queue: pointers wrap modulo DEPTH; occupancy counter ranges 0..DEPTH.
- inst_out and inst_pc are 0 whenever the queue is empty.

Test Plan:
- Reset release, MEM_BYTES=20, inst_ready=1, memory holding words W0..W4 at 0,4,..,16 -> W0..W4 appear on consecutive cycles with inst_pc 0,4,8,12,16. Then state END, inst_valid=0, fetch_count=5, imem_addr=20.
- inst_ready=0 from reset for 6 cycles -> queue fills (2 entries) with pc advanced to 8 and held. Raise ready -> W0, W1, W2 delivered in order with no duplicate or skip.
- Redirect to 8 while the queue holds {pc0, pc4} and ready=1 -> pc0 consumed, pc4 flushed. Next valid word is W2 with inst_pc=8 two cycles later; fetch_count excludes nothing already pushed.
- In END, redirect to 4 -> state RUN, W1..W4 refetched. Redirect to 24 -> END on the following cycle, no push.
- Redirect target 6 -> fault=1 and no further pushes. A subsequent redirect to 0 is ignored. Assert reset -> fault=0 and fetch restarts at 0.
- Assert reset mid-run with 2 queued entries -> inst_valid=0 and imem_addr=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, reads the instruction memory and
// buffers fetched words with their PCs in a small prefetch queue for decode.
module fetch_sequencer #(
    parameter int unsigned MEM_BYTES = 20,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fault,
    output logic [15:0] fetch_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_END,
        ST_FAULT
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               fault_q, fault_d;
    logic [15:0]        fetchCount_q, fetchCount_d;
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        instrBuf_q [DEPTH];
    logic [31:0]        pcBuf_q [DEPTH];

    logic pushEn;
    logic popEn;
    logic flush;
    logic pcInRange;
    logic qFull;

    // Next-state logic: a redirect outranks fetching, and FAULT only drains.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_d      = fault_q;
        fetchCount_d = fetchCount_q;
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        count_d      = count_q;
        pushEn       = 1'b0;
        flush        = 1'b0;
        popEn        = (count_q != '0) && inst_ready;
        pcInRange    = ({1'b0, pc_q} + 33'd4) <= MEM_LIMIT;
        qFull        = (count_q == FULL_COUNT);

        if (state_q != ST_FAULT && redirect_valid) begin
            flush = 1'b1;
            if (redirect_target[1:0] != 2'b00) begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end else begin
                pc_d    = redirect_target;
                state_d = ST_RUN;
            end
        end else if (state_q == ST_RUN && fetch_en) begin
            if (!pcInRange) begin
                state_d = ST_END;
            end else if (!qFull || popEn) begin
                pushEn = 1'b1;
            end
        end

        if (pushEn) begin
            pc_d         = pc_q + 32'd4;
            fetchCount_d = fetchCount_q + 16'd1;
        end

        // A same-cycle pop is honoured by the flush simply because everything goes.
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            wrPtr_d = wrPtr_q + PTR_W'(pushEn);
            rdPtr_d = rdPtr_q + PTR_W'(popEn);
            count_d = count_q + CNT_W'(pushEn) - CNT_W'(popEn);
        end
    end

    // State, pointers and queue storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            fault_q      <= 1'b0;
            fetchCount_q <= '0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instrBuf_q[i] <= '0;
                pcBuf_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fault_q      <= fault_d;
            fetchCount_q <= fetchCount_d;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            count_q      <= count_d;
            if (pushEn) begin
                instrBuf_q[wrPtr_q] <= imem_instr;
                pcBuf_q[wrPtr_q]    <= pc_q;
            end
        end
    end

    assign imem_addr   = pc_q;
    assign inst_valid  = (count_q != '0);
    assign inst_out    = inst_valid ? instrBuf_q[rdPtr_q] : 32'd0;
    assign inst_pc     = inst_valid ? pcBuf_q[rdPtr_q] : 32'd0;
    assign fault       = fault_q;
    assign fetch_count = fetchCount_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_fetch_sequencer;

    localparam int unsigned MEM_BYTES = 20;
    localparam int unsigned DEPTH     = 2;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fault;
    logic [15:0] fetch_count;

    int vectors;
    int miscompares;

    fetch_sequencer #(
        .MEM_BYTES(MEM_BYTES),
        .DEPTH(DEPTH),
        .RESET_PC(32'd0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetch_en(fetch_en),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_out(inst_out),
        .inst_pc(inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .fault(fault),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word k of memory holds 0x0C000000 + k; anything outside reads as all ones.
    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (a < MEM_BYTES && a[1:0] == 2'b00) return 32'h0C00_0000 + {2'b00, a[31:2]};
        return 32'hFFFF_FFFF;
    endfunction

    assign imem_instr = memRead(imem_addr);

    // Reference model: a queue of fetched words plus the architectural PC.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] mPc;
    bit          mEnded;
    bit          mFaulted;
    int          mCount;

    task automatic modelReset();
        mq.delete();
        mPc      = 32'd0;
        mEnded   = 1'b0;
        mFaulted = 1'b0;
        mCount   = 0;
    endtask

    task automatic modelStep(input bit rv, input logic [31:0] tgt, input bit rdy, input bit en);
        bit pop;
        bit canPush;
        entry_t e;
        pop = (mq.size() > 0) && rdy;
        if (!mFaulted && rv) begin
            mq.delete();
            if (tgt % 4 != 0) begin
                mFaulted = 1'b1;
            end else begin
                mPc    = tgt;
                mEnded = 1'b0;
            end
        end else begin
            canPush = !mFaulted && !mEnded && en;
            if (canPush && (longint'(mPc) + 4 > longint'(MEM_BYTES))) begin
                mEnded  = 1'b1;
                canPush = 1'b0;
            end
            if (canPush && mq.size() == DEPTH && !pop) canPush = 1'b0;
            if (pop) void'(mq.pop_front());
            if (canPush) begin
                e.instr = memRead(mPc);
                e.pc    = mPc;
                mq.push_back(e);
                mPc    = mPc + 32'd4;
                mCount = mCount + 1;
            end
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Compare every DUT output with the reference model.
    task automatic checkOutput();
        logic [31:0] expInstr;
        logic [31:0] expPc;
        expInstr = (mq.size() > 0) ? mq[0].instr : 32'd0;
        expPc    = (mq.size() > 0) ? mq[0].pc : 32'd0;
        checkVal("inst_valid", {31'd0, inst_valid}, {31'd0, mq.size() > 0});
        checkVal("inst_out", inst_out, expInstr);
        checkVal("inst_pc", inst_pc, expPc);
        checkVal("imem_addr", imem_addr, mPc);
        checkVal("fault", {31'd0, fault}, {31'd0, mFaulted});
        checkVal("fetch_count", {16'd0, fetch_count}, {16'd0, mCount[15:0]});
    endtask

    // One clock: drive at the falling edge, step the model, sample after the rising edge.
    task automatic applyStimulus(input bit rv, input logic [31:0] tgt, input bit rdy, input bit en);
        @(negedge clk);
        redirect_valid  = rv;
        redirect_target = tgt;
        inst_ready      = rdy;
        fetch_en        = en;
        modelStep(rv, tgt, rdy, en);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        inst_ready      = 1'b1;
        fetch_en        = 1'b1;
        modelReset();
        #1;
        checkOutput();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        bit          rv;
        logic [31:0] tgt;
        bit          rdy;
        bit          en;
        bit          expValid;
        logic [31:0] expInstr;
        logic [31:0] expPc;
        logic [31:0] expAddr;
        logic [15:0] expCount;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [31:0] tgt;
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b1;
        fetch_en        = 1'b0;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        modelReset();

        vecs[0]  = '{0, 32'd0,  1, 1, 1, 32'h0C00_0000, 32'd0,  32'd4,  16'd1};
        vecs[1]  = '{0, 32'd0,  1, 1, 1, 32'h0C00_0001, 32'd4,  32'd8,  16'd2};
        vecs[2]  = '{0, 32'd0,  1, 1, 1, 32'h0C00_0002, 32'd8,  32'd12, 16'd3};
        vecs[3]  = '{0, 32'd0,  1, 1, 1, 32'h0C00_0003, 32'd12, 32'd16, 16'd4};
        vecs[4]  = '{0, 32'd0,  1, 1, 1, 32'h0C00_0004, 32'd16, 32'd20, 16'd5};
        vecs[5]  = '{0, 32'd0,  1, 1, 0, 32'd0,         32'd0,  32'd20, 16'd5};
        vecs[6]  = '{0, 32'd0,  1, 1, 0, 32'd0,         32'd0,  32'd20, 16'd5};
        vecs[7]  = '{1, 32'd4,  1, 1, 0, 32'd0,         32'd0,  32'd4,  16'd5};
        vecs[8]  = '{0, 32'd0,  1, 1, 1, 32'h0C00_0001, 32'd4,  32'd8,  16'd6};
        vecs[9]  = '{0, 32'd0,  1, 1, 1, 32'h0C00_0002, 32'd8,  32'd12, 16'd7};
        vecs[10] = '{1, 32'd24, 1, 1, 0, 32'd0,         32'd0,  32'd24, 16'd7};
        vecs[11] = '{0, 32'd0,  1, 1, 0, 32'd0,         32'd0,  32'd24, 16'd7};
        vecs[12] = '{0, 32'd0,  1, 1, 0, 32'd0,         32'd0,  32'd24, 16'd7};

        // Directed table: full sweep to END, redirect out of END, redirect past memory.
        doReset();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].rv, vecs[i].tgt, vecs[i].rdy, vecs[i].en);
            checkVal($sformatf("vec%0d.valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].expValid});
            checkVal($sformatf("vec%0d.instr", i), inst_out, vecs[i].expInstr);
            checkVal($sformatf("vec%0d.pc", i), inst_pc, vecs[i].expPc);
            checkVal($sformatf("vec%0d.addr", i), imem_addr, vecs[i].expAddr);
            checkVal($sformatf("vec%0d.count", i), {16'd0, fetch_count}, {16'd0, vecs[i].expCount});
            checkVal($sformatf("vec%0d.fault", i), {31'd0, fault}, 32'd0);
        end

        // Backpressure from reset: queue fills, PC holds at 8, then drains in order.
        doReset();
        repeat (6) applyStimulus(0, 32'd0, 0, 1);
        checkOutput();
        checkVal("bp.addr", imem_addr, 32'd8);
        checkVal("bp.head_pc", inst_pc, 32'd0);
        checkVal("bp.count", {16'd0, fetch_count}, 32'd2);
        applyStimulus(0, 32'd0, 1, 1);
        checkOutput();
        checkVal("bp.second_pc", inst_pc, 32'd4);
        applyStimulus(0, 32'd0, 1, 1);
        checkOutput();
        checkVal("bp.third_pc", inst_pc, 32'd8);
        checkVal("bp.third_instr", inst_out, 32'h0C00_0002);

        // Redirect with a full queue while decode pops the head.
        doReset();
        repeat (2) applyStimulus(0, 32'd0, 0, 1);
        applyStimulus(1, 32'd8, 1, 1);
        checkOutput();
        checkVal("redir.valid", {31'd0, inst_valid}, 32'd0);
        checkVal("redir.count", {16'd0, fetch_count}, 32'd2);
        applyStimulus(0, 32'd0, 0, 1);
        checkOutput();
        checkVal("redir.pc", inst_pc, 32'd8);
        checkVal("redir.count2", {16'd0, fetch_count}, 32'd3);

        // Misaligned redirect faults; later redirects are ignored; reset clears it.
        applyStimulus(1, 32'd6, 1, 1);
        checkOutput();
        checkVal("fault.set", {31'd0, fault}, 32'd1);
        checkVal("fault.addr", imem_addr, 32'd12);
        repeat (3) begin
            applyStimulus(0, 32'd0, 1, 1);
            checkOutput();
        end
        applyStimulus(1, 32'd0, 1, 1);
        checkOutput();
        checkVal("fault.ignored", imem_addr, 32'd12);
        checkVal("fault.sticky", {31'd0, fault}, 32'd1);
        doReset();
        checkVal("fault.cleared", {31'd0, fault}, 32'd0);
        applyStimulus(0, 32'd0, 1, 1);
        checkOutput();
        checkVal("fault.restart", inst_pc, 32'd0);

        // Reset mid-cycle with a full queue takes effect without a clock edge.
        repeat (3) applyStimulus(0, 32'd0, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        checkVal("async.valid", {31'd0, inst_valid}, 32'd0);
        checkVal("async.addr", imem_addr, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset();
            end else begin
                case ($urandom_range(0, 7))
                    6: tgt = 32'($urandom_range(1, 3)) + 32'd4 * 32'($urandom_range(0, 5));
                    7: tgt = $urandom() & 32'hFFFF_FFFC;
                    default: tgt = 32'd4 * 32'($urandom_range(0, 7));
                endcase
                applyStimulus($urandom_range(0, 11) == 0, tgt,
                              $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
                checkOutput();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
